kamacore_stage_wb: RTL
======================

# kamacore_stage_wb

Writeback stage of the kamacore five-stage pipeline, directly downstream of the memory stage. It consumes the MEM/WB stage buffer and selects the final result: ALU result, or the load word sign/zero-extended per funct3 and byte offset. It commits that result to the architectural register file, which it owns. It also provides the decode stage's two register read ports with write-through bypass, drives the WB-level forwarding interface, and counts retired instructions.

## Interface
Parameters
- CPU_WIDTH, package constant 32: datapath width.
- REG_COUNT, package constant 32: architectural registers; x0 hardwired to zero.

Ports
- clk  input  1: clock.
- rst  input  1: reset, synchronous, active-low.
- pipeline_mem_wb  kamacore_pipeline_stage (consumer)  —: end_result, instruction, data_memory_result, control_signals (rd_we, mem_read).
- forwarding  kamacore_forwarding_if (driver)  —: data_original, we, a.
- rs1_addr  input  5: decode read port 1 address.
- rs2_addr  input  5: decode read port 2 address.
- rs1_data  output  CPU_WIDTH: read port 1 data.
- rs2_data  output  CPU_WIDTH: read port 2 data.
- instret  output  64: retired-instruction count.

## Operation
- rd = instruction[11:7]; funct3 = instruction[14:12]; off = end_result[1:0].
- wb_data: if mem_read = 0, it is end_result. Otherwise the load is extracted from data_memory_result:
  - LB 000: byte[off], sign-extended.
  - LBU 100: byte[off], zero-extended.
  - LH 001: half[off[1]], sign-extended; off[0] ignored.
  - LHU 101: half[off[1]], zero-extended; off[0] ignored.
  - LW 010: full word.
  - Any other funct3: full word.
- Commit: wr_en = rd_we && rd != 0. When wr_en, regs[rd] <= wb_data on the clk edge.
- Read ports (combinational):
  - Address 0 returns 0.
  - Address == rd with wr_en returns wb_data (write-through).
  - Otherwise returns regs[addr].
  - Both ports are independent; both may hit the bypass in the same cycle.
- Forwarding (combinational):
  - data_original = wb_data.
  - we = wr_en.
  - a = rd.
- Retirement:
  - A slot is valid when instruction != 0; all-zero is a bubble (reset value of the MEM/WB buffer).
  - instret increments by 1 per valid slot and wraps from 2^64-1 to 0.
- Reset (rst = 0 at a clk edge):
  - All regs cleared to 0 and instret cleared to 0.
  - Any write presented in that cycle is discarded.
  - Reset mid-stream drops the in-flight writeback; no partial state is kept.

## Timing
- The stage adds no latency: wb_data, forwarding and read-port outputs are combinational from MEM/WB buffer contents.
- Register array update is visible in regs one cycle after commit. The same-cycle view is provided by bypass.
- instret reflects a retirement the cycle after the slot is present.
- Reset values:
  - rs1_data, rs2_data = 0 after reset when no write is pending.
  - instret = 0.
  - Forwarding we = 0, because the buffer resets to zero with rd_we = 0.
- Simultaneous rd_we with rd = 0: no write, forwarding we = 0, reads of x0 remain 0.
- No handshake or stall: the stage accepts one slot per cycle unconditionally.

## Structure
- Shared package (kamacore_pkg):
  - CPU_WIDTH, REG_COUNT, REG_ADDR_WIDTH = 5.
  - kamacore_load_e enum for funct3 load encodings.
  - Control-signal struct with rd_we and mem_read fields.
- Sub-module kamacore_regfile: 2 read / 1 write, synchronous reset clear, x0 zero, write-through bypass. The stage instantiates it and holds the load-extract logic and the instret counter.

## Test plan
- ALU writeback:
  - Stimulus: rd_we = 1, mem_read = 0, rd = 5, end_result = 0x1234_5678.
  - Response: same-cycle rs1_addr = 5 returns 0x1234_5678 via bypass. Next cycle, rs1_data = 0x1234_5678 from the array. instret = 1.
- Load extraction, data_memory_result = 0x80FF_7F01:
  - LB, off = 3 -> 0xFFFF_FF80.
  - LBU, off = 2 -> 0x0000_00FF.
  - LH, off = 2 -> 0xFFFF_80FF.
  - LHU, off = 0 -> 0x0000_7F01.
  - LW -> 0x80FF_7F01.
- x0 protection:
  - Stimulus: rd_we = 1, rd = 0, wb_data = 0xDEAD_BEEF.
  - Response: forwarding we = 0, rs2_addr = 0 returns 0, instret increments.
- Bubbles:
  - Stimulus: 4 cycles of all-zero instruction.
  - Response: no register changes, instret unchanged.
- Reset mid-stream:
  - Stimulus: write x7 = 0x55; next cycle hold rst = 0 while presenting a write x8 = 0xAA.
  - Response: after release, x7 = 0, x8 = 0, instret = 0.
- Counter wrap:
  - Stimulus: force instret to 2^64-1, then retire one instruction.
  - Response: instret = 0.

Source files
------------

// File: rtl/kamacore_pkg.sv
// Shared kamacore types, widths and the load-extraction helper.
package kamacore_pkg;

  localparam int CPU_WIDTH      = 32;
  localparam int REG_COUNT      = 32;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int INSTR_WIDTH    = 32;

  typedef enum logic [2:0] {
    LOAD_LB  = 3'b000,
    LOAD_LH  = 3'b001,
    LOAD_LW  = 3'b010,
    LOAD_LBU = 3'b100,
    LOAD_LHU = 3'b101
  } kamacore_load_e;

  typedef struct packed {
    logic rd_we;
    logic mem_read;
  } kamacore_ctrl_t;

  // Select the addressed byte/half of a memory word and extend it per funct3.
  // Unknown encodings return the full word so a malformed load still commits.
  function automatic logic [CPU_WIDTH-1:0] load_extract(
    input logic [2:0]           funct3,
    input logic [1:0]           off,
    input logic [CPU_WIDTH-1:0] word
  );
    logic [7:0]           byte_s;
    logic [15:0]          half_s;
    logic [CPU_WIDTH-1:0] res_s;
    byte_s = word[{off, 3'b000} +: 8];
    half_s = off[1] ? word[31:16] : word[15:0];
    case (kamacore_load_e'(funct3))
      LOAD_LB:  res_s = {{(CPU_WIDTH-8){byte_s[7]}}, byte_s};
      LOAD_LBU: res_s = {{(CPU_WIDTH-8){1'b0}}, byte_s};
      LOAD_LH:  res_s = {{(CPU_WIDTH-16){half_s[15]}}, half_s};
      LOAD_LHU: res_s = {{(CPU_WIDTH-16){1'b0}}, half_s};
      LOAD_LW:  res_s = word;
      default:  res_s = word;
    endcase
    return res_s;
  endfunction

endpackage

// File: rtl/kamacore_forwarding_if.sv
// Forwarding bus from a late stage back to the execute-stage operand muxes.
interface kamacore_forwarding_if;
  import kamacore_pkg::*;

  logic [CPU_WIDTH-1:0]      data_original;
  logic                      we;
  logic [REG_ADDR_WIDTH-1:0] a;

  modport driver   (output data_original, we, a);
  modport receiver (input  data_original, we, a);
endinterface

// File: rtl/kamacore_pipeline_stage.sv
// Stage buffer between two pipeline stages (used here as MEM/WB).
interface kamacore_pipeline_stage;
  import kamacore_pkg::*;

  logic [CPU_WIDTH-1:0]   end_result;
  logic [INSTR_WIDTH-1:0] instruction;
  logic [CPU_WIDTH-1:0]   data_memory_result;
  kamacore_ctrl_t         control_signals;

  modport producer (output end_result, instruction, data_memory_result, control_signals);
  modport consumer (input  end_result, instruction, data_memory_result, control_signals);
endinterface

// File: rtl/kamacore_regfile.sv
// Architectural register file: 2 read / 1 write, x0 reads zero,
// same-cycle write-through so readers never see a stale value.
module kamacore_regfile
  import kamacore_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [REG_ADDR_WIDTH-1:0] wr_addr,
  input  logic [CPU_WIDTH-1:0]      wr_data,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_addr,
  output logic [CPU_WIDTH-1:0]      rs1_data,
  output logic [CPU_WIDTH-1:0]      rs2_data
);

  logic [CPU_WIDTH-1:0] regs_r [REG_COUNT];

  // Clear the whole array on reset (dropping any concurrent write), else commit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs_r[i] <= '0;
      end
    end else if (wr_en && (wr_addr != 5'd0)) begin
      regs_r[wr_addr] <= wr_data;
    end
  end

  // Read port 1: x0 is zero, a matching in-flight write bypasses the array.
  always_comb begin
    rs1_data = '0;
    if (rs1_addr == 5'd0) begin
      rs1_data = '0;
    end else if (wr_en && (rs1_addr == wr_addr)) begin
      rs1_data = wr_data;
    end else begin
      rs1_data = regs_r[rs1_addr];
    end
  end

  // Read port 2: same rules as port 1, fully independent of it.
  always_comb begin
    rs2_data = '0;
    if (rs2_addr == 5'd0) begin
      rs2_data = '0;
    end else if (wr_en && (rs2_addr == wr_addr)) begin
      rs2_data = wr_data;
    end else begin
      rs2_data = regs_r[rs2_addr];
    end
  end

endmodule

// File: rtl/kamacore_stage_wb.sv
// kamacore writeback stage: final result select, register commit,
// decode read ports with bypass, WB forwarding and retirement counter.
module kamacore_stage_wb
  import kamacore_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  kamacore_pipeline_stage.consumer  pipeline_mem_wb,
  kamacore_forwarding_if.driver     forwarding,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_addr,
  output logic [CPU_WIDTH-1:0]      rs1_data,
  output logic [CPU_WIDTH-1:0]      rs2_data,
  output logic [63:0]               instret
);

  logic [REG_ADDR_WIDTH-1:0] rd_s;
  logic [2:0]                funct3_s;
  logic [1:0]                off_s;
  logic [CPU_WIDTH-1:0]      wb_data_s;
  logic                      wr_en_s;
  logic                      valid_s;
  logic [63:0]               instret_r;

  assign rd_s     = pipeline_mem_wb.instruction[11:7];
  assign funct3_s = pipeline_mem_wb.instruction[14:12];
  assign off_s    = pipeline_mem_wb.end_result[1:0];
  // An all-zero instruction is the buffer's reset/bubble value, not a real op.
  assign valid_s  = (pipeline_mem_wb.instruction != 32'd0);
  assign wr_en_s  = pipeline_mem_wb.control_signals.rd_we && (rd_s != 5'd0);

  // Final result: ALU value, or the extracted load for memory reads.
  always_comb begin
    wb_data_s = pipeline_mem_wb.end_result;
    if (pipeline_mem_wb.control_signals.mem_read) begin
      wb_data_s = load_extract(funct3_s, off_s, pipeline_mem_wb.data_memory_result);
    end else begin
      wb_data_s = pipeline_mem_wb.end_result;
    end
  end

  assign forwarding.data_original = wb_data_s;
  assign forwarding.we            = wr_en_s;
  assign forwarding.a             = rd_s;

  kamacore_regfile u_regfile (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en_s),
    .wr_addr  (rd_s),
    .wr_data  (wb_data_s),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data)
  );

  // Count every non-bubble slot; the 64-bit add wraps naturally at the top.
  always_ff @(posedge clk) begin
    if (!rst) begin
      instret_r <= 64'd0;
    end else if (valid_s) begin
      instret_r <= instret_r + 64'd1;
    end
  end

  assign instret = instret_r;

endmodule
